cache_stats_unit: RTL and testbench

- Synthesisable statistics block that sits beside the L2 cache and counts per-cycle cache events: hit, miss, read, write, plus any extra channels.
- Supersedes bench-only statistics integers with parametrised saturating counters.
- Adds an atomic snapshot/clear handshake and an indexed readout port.
- Adds a sequential hit-ratio divider that is safe when there are zero accesses.

---
 rtl/cache_stats_unit.sv | 161 ++++++++++++++++
 tb/tb_cache_stats_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_stats_unit.sv
// Cache event statistics: saturating per-channel counters, an atomic
// snapshot/clear handshake, indexed snapshot readout, and a sequential
// hit-ratio divider (hits / (hits + misses)) that tolerates zero accesses.
module cache_stats_unit #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 32,
  parameter int FRAC_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_EVENTS-1:0]         event_in,
  input  logic                          clear,
  input  logic                          snap_req,
  input  logic                          snap_clear,
  output logic                          snap_ack,
  input  logic [$clog2(NUM_EVENTS)-1:0] rd_idx,
  output logic [CNT_W-1:0]              rd_data,
  input  logic                          ratio_start,
  output logic                          ratio_busy,
  output logic                          ratio_valid,
  output logic [FRAC_W:0]               ratio_out,
  output logic [NUM_EVENTS-1:0]         sat_flags
);

  localparam int IDX_W  = $clog2(NUM_EVENTS);
  localparam int TAB_N  = 1 << IDX_W;
  localparam int STEP_W = $clog2(FRAC_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(FRAC_W);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  logic [CNT_W-1:0]      r_live [NUM_EVENTS];
  logic [CNT_W-1:0]      r_snap [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] r_sat;
  logic                  r_ack;
  logic [CNT_W-1:0]      r_rd;
  logic [CNT_W-1:0]      w_rd_tab [TAB_N];

  state_t                r_state, w_state_nxt;
  logic [CNT_W+1:0]      r_rem;
  logic [CNT_W:0]        r_den;
  logic [FRAC_W-1:0]     r_quo;
  logic [STEP_W-1:0]     r_step;
  logic [FRAC_W:0]       r_ratio;
  logic [CNT_W:0]        w_den_start;
  logic                  w_ge;
  logic [CNT_W+1:0]      w_rem_sub;

  // Live counters: clear wins, snap_clear restarts from this cycle's event, else saturating count.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) r_live[i] <= '0;
      r_sat <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clear) begin
          r_live[i] <= '0;
          r_sat[i]  <= 1'b0;
        end else if (snap_req && snap_clear) begin
          r_live[i] <= CNT_W'(event_in[i]);
          r_sat[i]  <= 1'b0;
        end else if (event_in[i] && (r_live[i] != CNT_MAX)) begin
          r_live[i] <= r_live[i] + CNT_W'(1);
          if (r_live[i] == CNT_MAX - CNT_W'(1)) r_sat[i] <= 1'b1;
        end
      end
    end
  end

  // Snapshot capture of the pre-edge live values, plus the acknowledge pulse.
  // NOTE: the snapshot array is reset because its contents are observable through rd_data and the divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) r_snap[i] <= '0;
      r_ack <= 1'b0;
    end else begin
      if (snap_req) r_snap <= r_live;
      r_ack <= snap_req;
    end
  end

  // Readout table padded with zeros so indices beyond NUM_EVENTS read 0.
  for (genvar g = 0; g < TAB_N; g++) begin : g_tab
    if (g < NUM_EVENTS) begin : g_used
      assign w_rd_tab[g] = r_snap[g];
    end else begin : g_pad
      assign w_rd_tab[g] = '0;
    end
  end

  // Registered snapshot readout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd <= '0;
    else       r_rd <= w_rd_tab[rd_idx];
  end

  // Divider state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Divider next state and one restoring-division step; a zero denominator
  // resolves in its first CALC cycle without iterating.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_den_start = {1'b0, r_snap[0]} + {1'b0, r_snap[1]};
    w_ge        = (r_rem >= {1'b0, r_den});
    w_rem_sub   = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;
    unique case (r_state)
      S_IDLE: if (ratio_start) w_state_nxt = S_CALC;
      S_CALC: if ((r_den == '0) || (r_step == LAST_STEP)) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Divider datapath: latch operands at start, shift in one quotient bit per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem   <= '0;
      r_den   <= '0;
      r_quo   <= '0;
      r_step  <= '0;
      r_ratio <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ratio_start) begin
            r_rem  <= {2'b00, r_snap[0]};
            r_den  <= w_den_start;
            r_quo  <= '0;
            r_step <= '0;
          end
        end
        S_CALC: begin
          if (r_den == '0) begin
            r_ratio <= '0;
          end else begin
            r_rem  <= w_rem_sub << 1;
            r_quo  <= {r_quo[FRAC_W-2:0], w_ge};
            r_step <= r_step + STEP_W'(1);
            if (r_step == LAST_STEP) r_ratio <= {r_quo, w_ge};
          end
        end
        default: ;
      endcase
    end
  end

  assign snap_ack    = r_ack;
  assign rd_data     = r_rd;
  assign sat_flags   = r_sat;
  assign ratio_out   = r_ratio;
  assign ratio_valid = (r_state == S_DONE);
  assign ratio_busy  = (r_state == S_CALC) && (r_den != '0);

endmodule

// File: tb/tb_cache_stats_unit.sv
// Bench for cache_stats_unit: two instances (32-bit and 4-bit counters) share
// stimulus and are compared every cycle against a behavioural model.
module tb_cache_stats_unit;

  localparam int NE = 4;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NE-1:0] event_in = '0;
  logic          clear = 1'b0, snap_req = 1'b0, snap_clear = 1'b0, ratio_start = 1'b0;
  logic [1:0]    rd_idx = '0;

  logic          ack_b, busy_b, valid_b;
  logic [31:0]   rd_b;
  logic [FW:0]   ratio_b;
  logic [NE-1:0] sat_b;
  logic          ack_s, busy_s, valid_s;
  logic [3:0]    rd_s;
  logic [FW:0]   ratio_s;
  logic [NE-1:0] sat_s;

  int n_total = 0;
  int n_bad   = 0;

  // Model state, index 0 = 32-bit instance, 1 = 4-bit instance.
  longint        m_max   [2];
  longint        m_live  [2][NE];
  longint        m_snap  [2][NE];
  bit [NE-1:0]   m_sat   [2];
  longint        m_rd    [2];
  bit            m_ack;
  int            m_wait  [2];
  bit            m_valid [2];
  longint        m_den   [2];
  longint        m_res   [2];
  longint        m_ratio [2];

  cache_stats_unit #(.NUM_EVENTS(NE), .CNT_W(32), .FRAC_W(FW)) dut_big (
    .clk(clk), .reset(reset), .event_in(event_in), .clear(clear),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_ack(ack_b),
    .rd_idx(rd_idx), .rd_data(rd_b), .ratio_start(ratio_start),
    .ratio_busy(busy_b), .ratio_valid(valid_b), .ratio_out(ratio_b),
    .sat_flags(sat_b)
  );

  cache_stats_unit #(.NUM_EVENTS(NE), .CNT_W(4), .FRAC_W(FW)) dut_sml (
    .clk(clk), .reset(reset), .event_in(event_in), .clear(clear),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_ack(ack_s),
    .rd_idx(rd_idx), .rd_data(rd_s), .ratio_start(ratio_start),
    .ratio_busy(busy_s), .ratio_valid(valid_s), .ratio_out(ratio_s),
    .sat_flags(sat_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_max[0] = 64'hFFFF_FFFF;
    m_max[1] = 15;
    m_ack = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NE; i++) begin
        m_live[k][i] = 0;
        m_snap[k][i] = 0;
      end
      m_sat[k] = '0; m_rd[k] = 0; m_wait[k] = 0; m_valid[k] = 0;
      m_den[k] = 0; m_res[k] = 0; m_ratio[k] = 0;
    end
  endtask

  // Applies the effect of one rising edge with the current inputs.
  task automatic model_edge();
    longint n, d;
    bit     idle;
    m_ack = snap_req;
    for (int k = 0; k < 2; k++) begin
      m_rd[k] = m_snap[k][rd_idx];
      idle = (m_wait[k] == 0) && !m_valid[k];
      m_valid[k] = 0;
      if (m_wait[k] > 0) begin
        m_wait[k]--;
        if (m_wait[k] == 0) begin
          m_valid[k] = 1;
          m_ratio[k] = m_res[k];
        end
      end
      if (idle && ratio_start) begin
        n = m_snap[k][0];
        d = m_snap[k][0] + m_snap[k][1];
        m_den[k]  = d;
        m_res[k]  = (d == 0) ? 0 : (n << FW) / d;
        m_wait[k] = (d == 0) ? 1 : FW + 1;
      end
      if (snap_req)
        for (int i = 0; i < NE; i++) m_snap[k][i] = m_live[k][i];
      for (int i = 0; i < NE; i++) begin
        if (clear) begin
          m_live[k][i] = 0; m_sat[k][i] = 0;
        end else if (snap_req && snap_clear) begin
          m_live[k][i] = event_in[i]; m_sat[k][i] = 0;
        end else if (event_in[i] && m_live[k][i] < m_max[k]) begin
          m_live[k][i]++;
          if (m_live[k][i] == m_max[k]) m_sat[k][i] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("ack_big",   ack_b,   m_ack);
    check("rd_big",    rd_b,    m_rd[0]);
    check("sat_big",   sat_b,   m_sat[0]);
    check("valid_big", valid_b, m_valid[0]);
    check("busy_big",  busy_b,  (m_wait[0] > 0) && (m_den[0] != 0));
    check("ratio_big", ratio_b, m_ratio[0]);
    check("ack_sml",   ack_s,   m_ack);
    check("rd_sml",    rd_s,    m_rd[1]);
    check("sat_sml",   sat_s,   m_sat[1]);
    check("valid_sml", valid_s, m_valid[1]);
    check("busy_sml",  busy_s,  (m_wait[1] > 0) && (m_den[1] != 0));
    check("ratio_sml", ratio_s, m_ratio[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pulse_snap(input logic with_clear);
    snap_req = 1'b1; snap_clear = with_clear; step();
    snap_req = 1'b0; snap_clear = 1'b0;
  endtask

  // Asserts reset at a negedge, checks outputs drop at once, releases a cycle later.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_ack",   ack_b,   0);
    check("rst_rd",    rd_b,    0);
    check("rst_sat",   sat_b,   0);
    check("rst_busy",  busy_b,  0);
    check("rst_valid", valid_b, 0);
    check("rst_ratio", ratio_b, 0);
    check("rst_busy_sml", busy_s, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulses ratio_start then waits (bounded) for ratio_valid on the 32-bit instance.
  task automatic run_ratio(output int cyc, output int busy_cnt);
    ratio_start = 1'b1; step(); ratio_start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (!valid_b && cyc < 40) begin
      if (busy_b) busy_cnt++;
      step();
      cyc++;
    end
    check("ratio_valid_seen", valid_b, 1);
  endtask

  int exp_sweep [4] = '{10, 0, 10, 0};
  int cyc, busy_cnt;

  initial begin
    model_reset();
    @(negedge clk);
    apply_reset();

    // Hits and reads for 10 cycles, snapshot without clear, sweep readout.
    event_in = 4'b0101;
    repeat (10) step();
    event_in = '0;
    pulse_snap(1'b0);
    check("snap_ack_pulse", ack_b, 1);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      step();
      check("sweep_rd", rd_b, exp_sweep[i]);
    end
    check("snap_ack_drop", ack_b, 0);

    // 3 hits + 1 miss -> 0.75.
    pulse_clear();
    event_in = 4'b0001; repeat (3) step();
    event_in = 4'b0010; step();
    event_in = '0;
    pulse_snap(1'b0);
    run_ratio(cyc, busy_cnt);
    check("ratio_latency", cyc, FW + 2);
    check("ratio_busy_len", busy_cnt, FW + 1);
    check("ratio_075", ratio_b, 17'h0C000);
    step();
    check("ratio_valid_one_cycle", valid_b, 0);

    // Zero accesses -> ratio 0 after two cycles.
    pulse_clear();
    pulse_snap(1'b0);
    run_ratio(cyc, busy_cnt);
    check("zero_latency", cyc, 2);
    check("zero_ratio", ratio_b, 0);
    check("zero_no_busy", busy_cnt, 0);
    step();

    // Saturation on the 4-bit instance, then clear.
    event_in = 4'b0001; repeat (20) step();
    event_in = '0;
    pulse_snap(1'b0);
    check("sat_flag_set", sat_s[0], 1);
    rd_idx = 2'd0; step();
    check("sat_snap_sml", rd_s, 15);
    check("sat_snap_big", rd_b, 20);
    pulse_clear();
    check("sat_flag_clr", sat_s[0], 0);
    pulse_snap(1'b0);
    step();
    check("post_clear_snap", rd_s, 0);

    // snap_clear with a simultaneous event keeps that event.
    pulse_clear();
    event_in = 4'b0100; repeat (7) step();
    snap_req = 1'b1; snap_clear = 1'b1; step();
    snap_req = 1'b0; snap_clear = 1'b0; event_in = '0;
    rd_idx = 2'd2; step();
    check("snapclr_snap2", rd_b, 7);
    pulse_snap(1'b0);
    step();
    check("snapclr_live2", rd_b, 1);

    // Reset in the middle of a division, then a clean run.
    event_in = 4'b0011; repeat (5) step();
    event_in = '0;
    pulse_snap(1'b0);
    ratio_start = 1'b1; step(); ratio_start = 1'b0;
    repeat (5) step();
    check("busy_mid_calc", busy_b, 1);
    apply_reset();
    repeat (20) step();
    check("no_valid_after_abort", ratio_b, 0);
    event_in = 4'b0001; repeat (2) step();
    event_in = 4'b0010; repeat (2) step();
    event_in = '0;
    pulse_snap(1'b0);
    run_ratio(cyc, busy_cnt);
    check("after_rst_latency", cyc, FW + 2);
    check("after_rst_ratio", ratio_b, 17'h08000);
    step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      event_in    = NE'($urandom);
      clear       = ($urandom_range(0, 63) == 0);
      snap_req    = ($urandom_range(0, 7) == 0);
      snap_clear  = 1'($urandom_range(0, 1));
      rd_idx      = 2'($urandom);
      ratio_start = ($urandom_range(0, 7) == 0);
      step();
    end
    event_in = '0; clear = 1'b0; snap_req = 1'b0; snap_clear = 1'b0; ratio_start = 1'b0;
    repeat (25) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
